band_sequencer: RTL and testbench

BAND_SEQUENCER -- requirements
Module: band_sequencer

---
 rtl/band_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_band_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/band_sequencer.sv
// Band-switched RX/TX sequencer: steps the preamp, antenna relay and power amplifier
// through guarded on/off sequences around a push-to-talk request, with an optional transmit time-out.
module band_sequencer #(
    parameter int NBANDS      = 2,
    parameter int BAND_W      = 3,
    parameter int STEP_CYCLES = 1000,
    parameter int TOT_CYCLES  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ptt,
    input  logic [BAND_W-1:0] band,
    output logic [NBANDS-1:0] lna,
    output logic [NBANDS-1:0] ant,
    output logic [NBANDS-1:0] pa,
    output logic              tx_ok,
    output logic              busy,
    output logic              band_err,
    output logic              tot
);

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int TOT_W  = (TOT_CYCLES > 1) ? $clog2(TOT_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES - 1);
    localparam logic [TOT_W-1:0]  TOT_LAST  = TOT_W'((TOT_CYCLES > 0) ? TOT_CYCLES - 1 : 0);
    localparam logic [BAND_W:0]   NB        = (BAND_W + 1)'(NBANDS);

    typedef enum logic [2:0] {
        RX = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        TX = 3'd3,
        R1 = 3'd4,
        R2 = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic [TOT_W-1:0]    tot_cnt_q, tot_cnt_d;
    logic                tot_q, tot_d;
    logic [BAND_W-1:0]   chan_q, chan_d;
    logic                ptt_meta_q, ptt_s_q;
    logic [NBANDS-1:0]   lna_q, lna_d, ant_q, ant_d, pa_q, pa_d;
    logic                tx_ok_q, tx_ok_d, busy_q, busy_d, band_err_q, band_err_d;
    logic                active_s, band_ok_s, step_done_s;
    logic [NBANDS-1:0]   onehot_s;

    assign active_s    = ~ptt_s_q;
    assign band_ok_s   = ({1'b0, band} < NB);
    assign step_done_s = (cnt_q == '0);

    // Next-state logic: the single step counter guards T1/T2/R1/R2, the second counter times TX.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tot_cnt_d = tot_cnt_q;
        tot_d     = tot_q;
        chan_d    = chan_q;
        case (state_q)
            RX: begin
                if (band_ok_s) begin
                    chan_d = band;
                end else begin
                    chan_d = chan_q;
                end
                if (!active_s) begin
                    tot_d = 1'b0;
                end else if (band_ok_s && !tot_q) begin
                    state_d = T1;
                    cnt_d   = STEP_LOAD;
                end else begin
                    state_d = RX;
                end
            end
            T1: begin
                if (!active_s) begin
                    state_d = RX;
                end else if (step_done_s) begin
                    state_d = T2;
                    cnt_d   = STEP_LOAD;
                end else begin
                    cnt_d = cnt_q - STEP_W'(1);
                end
            end
            T2: begin
                if (!active_s) begin
                    state_d = R1;
                    cnt_d   = STEP_LOAD;
                end else if (step_done_s) begin
                    state_d   = TX;
                    tot_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q - STEP_W'(1);
                end
            end
            TX: begin
                if (!active_s) begin
                    state_d = R1;
                    cnt_d   = STEP_LOAD;
                end else if ((TOT_CYCLES > 0) && (tot_cnt_q == TOT_LAST)) begin
                    state_d = R1;
                    cnt_d   = STEP_LOAD;
                    tot_d   = 1'b1;
                end else begin
                    tot_cnt_d = tot_cnt_q + TOT_W'(1);
                end
            end
            R1: begin
                if (step_done_s) begin
                    state_d = R2;
                    cnt_d   = STEP_LOAD;
                end else begin
                    cnt_d = cnt_q - STEP_W'(1);
                end
            end
            R2: begin
                if (step_done_s) begin
                    state_d = RX;
                end else begin
                    cnt_d = cnt_q - STEP_W'(1);
                end
            end
            default: begin
                state_d = RX;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop aligned with the state change.
    always_comb begin
        onehot_s   = NBANDS'(1) << chan_d;
        lna_d      = '0;
        ant_d      = '0;
        pa_d       = '0;
        tx_ok_d    = 1'b0;
        busy_d     = (state_d != RX);
        band_err_d = 1'b0;
        case (state_d)
            RX: begin
                if (band_ok_s) begin
                    lna_d = onehot_s;
                end else begin
                    band_err_d = 1'b1;
                end
            end
            T2, R1: begin
                ant_d = onehot_s;
            end
            TX: begin
                ant_d   = onehot_s;
                pa_d    = onehot_s;
                tx_ok_d = 1'b1;
            end
            default: begin
                lna_d = '0;
            end
        endcase
    end

    // State, counters, ptt synchroniser and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RX;
            cnt_q      <= '0;
            tot_cnt_q  <= '0;
            tot_q      <= 1'b0;
            chan_q     <= '0;
            ptt_meta_q <= 1'b1;
            ptt_s_q    <= 1'b1;
            lna_q      <= '0;
            ant_q      <= '0;
            pa_q       <= '0;
            tx_ok_q    <= 1'b0;
            busy_q     <= 1'b0;
            band_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tot_cnt_q  <= tot_cnt_d;
            tot_q      <= tot_d;
            chan_q     <= chan_d;
            ptt_meta_q <= ptt;
            ptt_s_q    <= ptt_meta_q;
            lna_q      <= lna_d;
            ant_q      <= ant_d;
            pa_q       <= pa_d;
            tx_ok_q    <= tx_ok_d;
            busy_q     <= busy_d;
            band_err_q <= band_err_d;
        end
    end

    assign lna      = lna_q;
    assign ant      = ant_q;
    assign pa       = pa_q;
    assign tx_ok    = tx_ok_q;
    assign busy     = busy_q;
    assign band_err = band_err_q;
    assign tot      = tot_q;

endmodule

// File: tb/tb_band_sequencer.sv
// Directed bench for band_sequencer with STEP_CYCLES=4, TOT_CYCLES=20, NBANDS=2.
module tb_band_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ptt = 1'b1;
    logic [2:0] band = 3'd1;
    logic [1:0] lna, ant, pa;
    logic       tx_ok, busy, band_err, tot;

    int vectors = 0;
    int fails = 0;
    int tx_cnt;
    int pa_seen;

    band_sequencer #(
        .NBANDS(2), .BAND_W(3), .STEP_CYCLES(4), .TOT_CYCLES(20)
    ) dut (
        .clk(clk), .reset(reset), .ptt(ptt), .band(band),
        .lna(lna), .ant(ant), .pa(pa), .tx_ok(tx_ok),
        .busy(busy), .band_err(band_err), .tot(tot)
    );

    always #5 clk = ~clk;

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        adv(2);
        check("rst_lna", 32'(lna), 32'h0);
        check("rst_ant_pa", 32'({ant, pa}), 32'h0);
        check("rst_flags", 32'({tx_ok, busy, band_err, tot}), 32'h0);
        reset = 1'b1;
        adv(1);
        check("rst_rel_lna", 32'(lna), 32'h2);

        // full key/unkey sequence on band 1
        ptt = 1'b0;
        adv(2);
        check("key_e2_lna", 32'(lna), 32'h2);
        adv(1);
        check("key_e3_lna", 32'(lna), 32'h0);
        check("key_e3_busy", 32'(busy), 32'h1);
        adv(3);
        check("key_e6_ant", 32'(ant), 32'h0);
        adv(1);
        check("key_e7_ant", 32'(ant), 32'h2);
        check("key_e7_pa", 32'(pa), 32'h0);
        adv(3);
        check("key_e10_pa", 32'(pa), 32'h0);
        adv(1);
        check("key_e11_pa", 32'(pa), 32'h2);
        check("key_e11_txok", 32'(tx_ok), 32'h1);
        ptt = 1'b1;
        adv(2);
        check("rel_e2_pa", 32'(pa), 32'h2);
        adv(1);
        check("rel_e3_pa", 32'(pa), 32'h0);
        check("rel_e3_ant", 32'(ant), 32'h2);
        check("rel_e3_txok", 32'(tx_ok), 32'h0);
        adv(3);
        check("rel_e6_ant", 32'(ant), 32'h2);
        adv(1);
        check("rel_e7_ant", 32'(ant), 32'h0);
        adv(3);
        check("rel_e10_lna", 32'(lna), 32'h0);
        adv(1);
        check("rel_e11_lna", 32'(lna), 32'h2);
        check("rel_e11_busy", 32'(busy), 32'h0);

        // short ptt pulse aborts T1
        ptt = 1'b0;
        adv(3);
        check("pulse_e3_lna", 32'(lna), 32'h0);
        adv(1);
        ptt = 1'b1;
        pa_seen = 0;
        for (int i = 0; i < 3; i++) begin
            adv(1);
            if (ant != 2'b00 || pa != 2'b00) pa_seen++;
        end
        check("pulse_no_ant_pa", 32'(pa_seen), 32'h0);
        check("pulse_e7_lna", 32'(lna), 32'h2);
        check("pulse_e7_busy", 32'(busy), 32'h0);
        adv(4);
        check("pulse_idle_ant", 32'(ant), 32'h0);

        // release during T2
        ptt = 1'b0;
        adv(7);
        check("t2_e7_ant", 32'(ant), 32'h2);
        ptt = 1'b1;
        pa_seen = 0;
        adv(3);
        if (pa != 2'b00) pa_seen++;
        check("t2_e10_ant", 32'(ant), 32'h2);
        check("t2_e10_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 3; i++) begin
            adv(1);
            if (pa != 2'b00) pa_seen++;
        end
        check("t2_e13_ant", 32'(ant), 32'h2);
        adv(1);
        check("t2_e14_ant", 32'(ant), 32'h0);
        for (int i = 0; i < 3; i++) begin
            adv(1);
            if (pa != 2'b00) pa_seen++;
        end
        check("t2_e17_lna", 32'(lna), 32'h0);
        adv(1);
        check("t2_e18_lna", 32'(lna), 32'h2);
        check("t2_no_pa", 32'(pa_seen), 32'h0);

        // transmit time-out
        ptt = 1'b0;
        tx_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            adv(1);
            if (tx_ok) tx_cnt++;
            if (i == 31) check("tot_e31_flag", 32'(tot), 32'h1);
        end
        check("tot_tx_len", 32'(tx_cnt), 32'd20);
        check("tot_back_rx_lna", 32'(lna), 32'h2);
        check("tot_flag_held", 32'(tot), 32'h1);
        adv(5);
        check("tot_no_rekey", 32'(busy), 32'h0);
        ptt = 1'b1;
        adv(2);
        check("tot_e2_flag", 32'(tot), 32'h1);
        adv(1);
        check("tot_e3_clear", 32'(tot), 32'h0);

        // invalid band, then band change while keyed
        band = 3'd6;
        ptt = 1'b0;
        adv(5);
        check("berr_flag", 32'(band_err), 32'h1);
        check("berr_outs", 32'({lna, ant, pa}), 32'h0);
        check("berr_busy", 32'(busy), 32'h0);
        band = 3'd1;
        adv(1);
        check("berr_t1_busy", 32'(busy), 32'h1);
        check("berr_t1_flag", 32'(band_err), 32'h0);
        adv(8);
        check("bchg_tx_pa", 32'(pa), 32'h2);
        band = 3'd0;
        adv(2);
        check("bchg_ant_pa", 32'({ant, pa}), 32'hA);
        check("bchg_lna", 32'(lna), 32'h0);

        // reset during TX
        reset = 1'b0;
        adv(1);
        check("rst_tx_outs", 32'({lna, ant, pa}), 32'h0);
        check("rst_tx_txok", 32'(tx_ok), 32'h0);
        reset = 1'b1;
        ptt = 1'b1;
        adv(1);
        check("rst_tx_rel_lna", 32'(lna), 32'h1);
        check("rst_tx_rel_busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
